// File: rtl/control_sequencer.sv
// SAP-1.5 T-state microsequencer: registered step counter with a combinational
// control-word decode from (step, opcode, flags).
module control_sequencer #(
  parameter int unsigned OPCODE_WIDTH    = 4,
  parameter bit          VARIABLE_LENGTH = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_carry,
  input  logic                    flag_zero,
  output logic                    pc_enable,
  output logic                    pc_load,
  output logic                    pc_oe,
  output logic                    mar_load,
  output logic                    ram_oe,
  output logic                    ram_we,
  output logic                    ir_load,
  output logic                    ir_oe,
  output logic                    a_load,
  output logic                    a_oe,
  output logic                    b_load,
  output logic                    alu_oe,
  output logic                    alu_sub,
  output logic                    flags_load,
  output logic                    out_load,
  output logic                    halt,
  output logic [2:0]              t_state
);

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef struct packed {
    logic pc_enable;
    logic pc_load;
    logic pc_oe;
    logic mar_load;
    logic ram_oe;
    logic ram_we;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic alu_oe;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic halt;
  } ctrl_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic [2:0] last_step;
  logic [2:0] step;

  assign step = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_T0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    last_step = 3'd1;
    case (opcode)
      OP_LDA, OP_STA:                                 last_step = 3'd3;
      OP_ADD, OP_SUB:                                 last_step = 3'd4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:  last_step = 3'd2;
      default:                                        last_step = 3'd1;
    endcase
  end

  // ">=" rather than "==" so an opcode change mid-instruction still terminates.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_T0: state_d = ST_T1;
      ST_T1, ST_T2, ST_T3, ST_T4: begin
        if (state_q == ST_T2 && opcode == OP_HLT) begin
          state_d = ST_HALT;
        end else if (state_q == ST_T4 || (VARIABLE_LENGTH && step >= last_step)) begin
          state_d = ST_T0;
        end else begin
          state_d = state_e'(step + 3'd1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_T0: begin
        ctrl.pc_oe    = 1'b1;
        ctrl.mar_load = 1'b1;
      end
      ST_T1: begin
        ctrl.ram_oe    = 1'b1;
        ctrl.ir_load   = 1'b1;
        ctrl.pc_enable = 1'b1;
      end
      ST_T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_oe    = 1'b1;
            ctrl.mar_load = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_oe  = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_oe   = 1'b1;
            ctrl.pc_load = 1'b1;
          end
          OP_JC: begin
            ctrl.ir_oe   = 1'b1;
            ctrl.pc_load = flag_carry;
          end
          OP_JZ: begin
            ctrl.ir_oe   = 1'b1;
            ctrl.pc_load = flag_zero;
          end
          OP_OUT: begin
            ctrl.a_oe     = 1'b1;
            ctrl.out_load = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T3: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_oe = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_oe = 1'b1;
            ctrl.b_load = 1'b1;
          end
          OP_STA: begin
            ctrl.a_oe   = 1'b1;
            ctrl.ram_we = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl.alu_oe     = 1'b1;
          ctrl.a_load     = 1'b1;
          ctrl.flags_load = 1'b1;
          ctrl.alu_sub    = (opcode == OP_SUB);
        end
      end
      ST_HALT: ctrl.halt = 1'b1;
      default: ;
    endcase
    // Reset blanks the strobes combinationally so nothing leaks before the next edge.
    if (!reset) begin
      ctrl = '0;
    end
  end

  assign pc_enable  = ctrl.pc_enable;
  assign pc_load    = ctrl.pc_load;
  assign pc_oe      = ctrl.pc_oe;
  assign mar_load   = ctrl.mar_load;
  assign ram_oe     = ctrl.ram_oe;
  assign ram_we     = ctrl.ram_we;
  assign ir_load    = ctrl.ir_load;
  assign ir_oe      = ctrl.ir_oe;
  assign a_load     = ctrl.a_load;
  assign a_oe       = ctrl.a_oe;
  assign b_load     = ctrl.b_load;
  assign alu_oe     = ctrl.alu_oe;
  assign alu_sub    = ctrl.alu_sub;
  assign flags_load = ctrl.flags_load;
  assign out_load   = ctrl.out_load;
  assign halt       = ctrl.halt;
  assign t_state    = (state_q == ST_HALT) ? 3'd2 : step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a variable-length instance driven from a
// vector table plus hand sequences, and a fixed-length instance for five-step runs.
module tb_control_sequencer;

  localparam logic [15:0] PCE  = 16'h8000;
  localparam logic [15:0] PCL  = 16'h4000;
  localparam logic [15:0] PCO  = 16'h2000;
  localparam logic [15:0] MARL = 16'h1000;
  localparam logic [15:0] RAMO = 16'h0800;
  localparam logic [15:0] RAMW = 16'h0400;
  localparam logic [15:0] IRL  = 16'h0200;
  localparam logic [15:0] IRO  = 16'h0100;
  localparam logic [15:0] AL   = 16'h0080;
  localparam logic [15:0] AO   = 16'h0040;
  localparam logic [15:0] BL   = 16'h0020;
  localparam logic [15:0] ALUO = 16'h0010;
  localparam logic [15:0] SUBS = 16'h0008;
  localparam logic [15:0] FL   = 16'h0004;
  localparam logic [15:0] OUTL = 16'h0002;
  localparam logic [15:0] HLT  = 16'h0001;

  localparam logic [15:0] FETCH0 = PCO | MARL;
  localparam logic [15:0] FETCH1 = RAMO | IRL | PCE;

  typedef struct {
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [2:0]  t;
    logic [15:0] ctl;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       flag_carry, flag_zero;

  logic v1_pce, v1_pcl, v1_pco, v1_marl, v1_ramo, v1_ramw, v1_irl, v1_iro;
  logic v1_al, v1_ao, v1_bl, v1_aluo, v1_sub, v1_fl, v1_outl, v1_hlt;
  logic [2:0] v1_t;
  logic v0_pce, v0_pcl, v0_pco, v0_marl, v0_ramo, v0_ramw, v0_irl, v0_iro;
  logic v0_al, v0_ao, v0_bl, v0_aluo, v0_sub, v0_fl, v0_outl, v0_hlt;
  logic [2:0] v0_t;
  logic [15:0] c1, c0;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  control_sequencer #(.OPCODE_WIDTH(4), .VARIABLE_LENGTH(1'b1)) u_var (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_enable(v1_pce), .pc_load(v1_pcl), .pc_oe(v1_pco), .mar_load(v1_marl),
    .ram_oe(v1_ramo), .ram_we(v1_ramw), .ir_load(v1_irl), .ir_oe(v1_iro),
    .a_load(v1_al), .a_oe(v1_ao), .b_load(v1_bl), .alu_oe(v1_aluo),
    .alu_sub(v1_sub), .flags_load(v1_fl), .out_load(v1_outl), .halt(v1_hlt),
    .t_state(v1_t)
  );

  control_sequencer #(.OPCODE_WIDTH(4), .VARIABLE_LENGTH(1'b0)) u_fix (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_enable(v0_pce), .pc_load(v0_pcl), .pc_oe(v0_pco), .mar_load(v0_marl),
    .ram_oe(v0_ramo), .ram_we(v0_ramw), .ir_load(v0_irl), .ir_oe(v0_iro),
    .a_load(v0_al), .a_oe(v0_ao), .b_load(v0_bl), .alu_oe(v0_aluo),
    .alu_sub(v0_sub), .flags_load(v0_fl), .out_load(v0_outl), .halt(v0_hlt),
    .t_state(v0_t)
  );

  assign c1 = {v1_pce, v1_pcl, v1_pco, v1_marl, v1_ramo, v1_ramw, v1_irl, v1_iro,
               v1_al, v1_ao, v1_bl, v1_aluo, v1_sub, v1_fl, v1_outl, v1_hlt};
  assign c0 = {v0_pce, v0_pcl, v0_pco, v0_marl, v0_ramo, v0_ramw, v0_irl, v0_iro,
               v0_al, v0_ao, v0_bl, v0_aluo, v0_sub, v0_fl, v0_outl, v0_hlt};

  task automatic check(input string name, input logic [2:0] at, input logic [15:0] ac,
                       input logic [2:0] et, input logic [15:0] ec);
    checks++;
    if (at !== et || ac !== ec) begin
      failures++;
      $display("FAIL %s: got t_state=%0d ctrl=%04h, expected t_state=%0d ctrl=%04h",
               name, at, ac, et, ec);
    end
  endtask

  task automatic inv(input string name, input logic [15:0] ac);
    logic [4:0] drv;
    drv = {ac[13], ac[11], ac[8], ac[6], ac[4]};
    checks++;
    if ($countones(drv) > 1 || (ac[15] && ac[14]) || (ac[10] && ac[11])) begin
      failures++;
      $display("FAIL %s invariant: ctrl=%04h violates bus/pc/ram exclusivity", name, ac);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic c, input logic z,
                     input logic [2:0] t, input logic [15:0] ctl);
    vec_t v;
    v.op = op; v.c = c; v.z = z; v.t = t; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  initial begin
    // LDA, with a bogus opcode during T0 that must not matter
    add(4'hF, 0, 0, 3'd0, FETCH0);
    add(4'h1, 0, 0, 3'd1, FETCH1);
    add(4'h1, 0, 0, 3'd2, IRO | MARL);
    add(4'h1, 0, 0, 3'd3, RAMO | AL);
    // SUB
    add(4'h3, 0, 0, 3'd0, FETCH0);
    add(4'h3, 0, 0, 3'd1, FETCH1);
    add(4'h3, 0, 0, 3'd2, IRO | MARL);
    add(4'h3, 0, 0, 3'd3, RAMO | BL);
    add(4'h3, 0, 0, 3'd4, ALUO | AL | FL | SUBS);
    // ADD
    add(4'h2, 1, 1, 3'd0, FETCH0);
    add(4'h2, 1, 1, 3'd1, FETCH1);
    add(4'h2, 1, 1, 3'd2, IRO | MARL);
    add(4'h2, 1, 1, 3'd3, RAMO | BL);
    add(4'h2, 1, 1, 3'd4, ALUO | AL | FL);
    // STA
    add(4'h4, 0, 0, 3'd0, FETCH0);
    add(4'h4, 0, 0, 3'd1, FETCH1);
    add(4'h4, 0, 0, 3'd2, IRO | MARL);
    add(4'h4, 0, 0, 3'd3, AO | RAMW);
    // LDI, JMP
    add(4'h5, 0, 0, 3'd0, FETCH0);
    add(4'h5, 0, 0, 3'd1, FETCH1);
    add(4'h5, 0, 0, 3'd2, IRO | AL);
    add(4'h6, 0, 0, 3'd0, FETCH0);
    add(4'h6, 0, 0, 3'd1, FETCH1);
    add(4'h6, 0, 0, 3'd2, IRO | PCL);
    // JC taken, then JC not taken although carry was high during fetch
    add(4'h7, 1, 0, 3'd0, FETCH0);
    add(4'h7, 1, 0, 3'd1, FETCH1);
    add(4'h7, 1, 0, 3'd2, IRO | PCL);
    add(4'h7, 1, 0, 3'd0, FETCH0);
    add(4'h7, 1, 0, 3'd1, FETCH1);
    add(4'h7, 0, 1, 3'd2, IRO);
    // JZ taken, then not taken with carry high
    add(4'h8, 0, 1, 3'd0, FETCH0);
    add(4'h8, 0, 1, 3'd1, FETCH1);
    add(4'h8, 0, 1, 3'd2, IRO | PCL);
    add(4'h8, 1, 1, 3'd0, FETCH0);
    add(4'h8, 1, 1, 3'd1, FETCH1);
    add(4'h8, 1, 0, 3'd2, IRO);
    // OUT, NOP, undefined B
    add(4'hE, 0, 0, 3'd0, FETCH0);
    add(4'hE, 0, 0, 3'd1, FETCH1);
    add(4'hE, 0, 0, 3'd2, AO | OUTL);
    add(4'h0, 0, 0, 3'd0, FETCH0);
    add(4'h0, 0, 0, 3'd1, FETCH1);
    add(4'hB, 0, 0, 3'd0, FETCH0);
    add(4'hB, 0, 0, 3'd1, FETCH1);

    reset = 1'b0; opcode = 4'h1; flag_carry = 1'b0; flag_zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_var", v1_t, c1, 3'd0, 16'h0000);
    check("reset_fix", v0_t, c0, 3'd0, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      opcode = vecs[i].op; flag_carry = vecs[i].c; flag_zero = vecs[i].z;
      #1 check($sformatf("vec%0d_op%h_t%0d", i, vecs[i].op, vecs[i].t), v1_t, c1,
               vecs[i].t, vecs[i].ctl);
      inv($sformatf("vec%0d", i), c1);
      @(negedge clk);
    end
    #1 check("after_table_T0", v1_t, c1, 3'd0, FETCH0);

    // Reset in T3 of ADD: immediate blanking, restart at T0
    opcode = 4'h2; flag_carry = 1'b0; flag_zero = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("add_T3_pre_reset", v1_t, c1, 3'd3, RAMO | BL);
    reset = 1'b0;
    #1 check("add_reset_async", v1_t, c1, 3'd0, 16'h0000);
    @(negedge clk);
    #1 check("add_reset_held", v1_t, c1, 3'd0, 16'h0000);
    reset = 1'b1;
    #1 check("add_restart_T0", v1_t, c1, 3'd0, FETCH0);
    @(negedge clk);
    #1 check("add_restart_T1", v1_t, c1, 3'd1, FETCH1);

    // HLT: finish current cycle, then run a fresh HLT
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; #1; reset = 1'b1;
    opcode = 4'hF;
    #1 check("hlt_T0", v1_t, c1, 3'd0, FETCH0);
    @(negedge clk);
    #1 check("hlt_T1", v1_t, c1, 3'd1, FETCH1);
    @(negedge clk);
    #1 check("hlt_T2", v1_t, c1, 3'd2, 16'h0000);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      opcode = 4'(k);
      flag_carry = k[0]; flag_zero = k[1];
      #1 check($sformatf("halted_%0d", k), v1_t, c1, 3'd2, HLT);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1 check("halt_reset_async", v1_t, c1, 3'd0, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    #1 check("halt_exit_T0", v1_t, c1, 3'd0, FETCH0);

    // Fixed-length instance: LDI twice, undefined B, then HLT
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; opcode = 4'h5; flag_carry = 1'b0; flag_zero = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic [15:0] e;
      case (k % 5)
        0: e = FETCH0;
        1: e = FETCH1;
        2: e = IRO | AL;
        default: e = 16'h0000;
      endcase
      #1 check($sformatf("fix_ldi_%0d", k), v0_t, c0, 3'(k % 5), e);
      inv($sformatf("fix_ldi_%0d", k), c0);
      @(negedge clk);
    end
    opcode = 4'hB;
    for (int k = 0; k < 5; k++) begin
      logic [15:0] e;
      e = (k == 0) ? FETCH0 : (k == 1) ? FETCH1 : 16'h0000;
      #1 check($sformatf("fix_undef_%0d", k), v0_t, c0, 3'(k), e);
      inv($sformatf("fix_undef_%0d", k), c0);
      @(negedge clk);
    end
    opcode = 4'hF;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("fix_halted_%0d", k), v0_t, c0, 3'd2, HLT);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
